// File: rtl/shift_sequencer_if.sv
// Request/response bundle between two shift requesters, the result consumer and the sequencer.
// The master side drives requests and Rsp_Ready; the slave side (the sequencer) drives accepts and results.
interface shift_sequencer_if;
  logic [1:0]  Req_Valid;
  logic [1:0]  Req_Ready;
  logic [1:0]  Req_Op0;
  logic [1:0]  Req_Op1;
  logic [15:0] Req_A0;
  logic [15:0] Req_A1;
  logic [3:0]  Req_Imm0;
  logic [3:0]  Req_Imm1;
  logic        Rsp_Valid;
  logic        Rsp_Ready;
  logic [15:0] Rsp_Data;
  logic        Rsp_Id;

  modport master (
    output Req_Valid, Req_Op0, Req_Op1, Req_A0, Req_A1, Req_Imm0, Req_Imm1, Rsp_Ready,
    input  Req_Ready, Rsp_Valid, Rsp_Data, Rsp_Id
  );

  modport slave (
    input  Req_Valid, Req_Op0, Req_Op1, Req_A0, Req_A1, Req_Imm0, Req_Imm1, Rsp_Ready,
    output Req_Ready, Rsp_Valid, Rsp_Data, Rsp_Id
  );
endinterface

// File: rtl/shift_sequencer.sv
// Round-robin sequencer for a shared barrel shifter; result 2 cycles after accept (3 for ROR by non-zero amount).
// Accepts only in IDLE; holds the result in RESP while Rsp_Ready is low, with Req_Ready held at 00.
module shift_sequencer (
  input  logic                  clk,
  input  logic                  rst_n,
  shift_sequencer_if.slave      bus,
  output logic [15:0]           Sh_A,
  output logic [3:0]            Sh_Imm,
  output logic [1:0]            Sh_Ctrl,
  input  logic [15:0]           Sh_Result
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_ROR = 2'b01;

  localparam logic [1:0] CTRL_LEFT  = 2'b00;
  localparam logic [1:0] CTRL_RIGHT = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [3:0]  imm_q;
  logic        id_q;
  logic        last_id;
  logic [15:0] partial;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_id;

  logic        grant;
  logic [1:0]  ready;
  logic [1:0]  sel_op;
  logic [15:0] sel_a;
  logic [3:0]  sel_imm;
  logic [1:0]  sel_ctrl;
  logic        accept;

  // A tie goes to whichever requester was not served last.
  always_comb begin
    grant = 1'b0;
    case (bus.Req_Valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_id;
      default: grant = 1'b0;
    endcase
  end

  always_comb begin
    ready = 2'b00;
    if (rst_n && (state == IDLE)) begin
      ready[grant] = bus.Req_Valid[grant];
    end
  end

  assign accept   = |ready;
  assign sel_op   = grant ? bus.Req_Op1  : bus.Req_Op0;
  assign sel_a    = grant ? bus.Req_A1   : bus.Req_A0;
  assign sel_imm  = grant ? bus.Req_Imm1 : bus.Req_Imm0;
  // ROR's first pass is a logical right shift; the other ops map straight onto the shifter control.
  assign sel_ctrl = (sel_op == OP_ROR) ? CTRL_RIGHT : sel_op;

  // Sh_A doubles as the captured operand register; it is reused unchanged by the second ROR pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= OP_SLL;
      imm_q     <= 4'd0;
      id_q      <= 1'b0;
      last_id   <= 1'b1;
      partial   <= 16'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= 16'd0;
      rsp_id    <= 1'b0;
      Sh_A      <= 16'd0;
      Sh_Imm    <= 4'd0;
      Sh_Ctrl   <= CTRL_LEFT;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= sel_op;
            imm_q   <= sel_imm;
            id_q    <= grant;
            Sh_A    <= sel_a;
            Sh_Imm  <= sel_imm;
            Sh_Ctrl <= sel_ctrl;
            state   <= PASS1;
          end
        end
        PASS1: begin
          partial <= Sh_Result;
          if ((op_q == OP_ROR) && (imm_q != 4'd0)) begin
            Sh_Imm  <= 4'd0 - imm_q;
            Sh_Ctrl <= CTRL_LEFT;
            state   <= PASS2;
          end else begin
            Sh_A      <= 16'd0;
            Sh_Imm    <= 4'd0;
            Sh_Ctrl   <= CTRL_LEFT;
            rsp_data  <= Sh_Result;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        PASS2: begin
          Sh_A      <= 16'd0;
          Sh_Imm    <= 4'd0;
          Sh_Ctrl   <= CTRL_LEFT;
          rsp_data  <= partial | Sh_Result;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (bus.Rsp_Ready) begin
            rsp_valid <= 1'b0;
            last_id   <= id_q;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Req_Ready = ready;
  assign bus.Rsp_Valid = rsp_valid;
  assign bus.Rsp_Data  = rsp_data;
  assign bus.Rsp_Id    = rsp_id;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural barrel shifter on the Sh_* ports.
module tb_shift_sequencer;

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] ROR = 2'b01;
  localparam logic [1:0] SRL = 2'b10;
  localparam logic [1:0] SRA = 2'b11;

  logic        clk;
  logic        rst_n;
  logic [15:0] sh_a;
  logic [3:0]  sh_imm;
  logic [1:0]  sh_ctrl;
  logic [15:0] sh_result;

  int vectors;
  int miscompares;

  shift_sequencer_if bus();

  shift_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .Sh_A      (sh_a),
    .Sh_Imm    (sh_imm),
    .Sh_Ctrl   (sh_ctrl),
    .Sh_Result (sh_result)
  );

  always_comb begin
    case (sh_ctrl)
      2'b00:   sh_result = sh_a << sh_imm;
      2'b10:   sh_result = sh_a >> sh_imm;
      2'b11:   sh_result = 16'($signed(sh_a) >>> sh_imm);
      default: sh_result = 16'hDEAD;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Raises one requester's valid, waits for its accept edge, and returns in cycle 1 with valid dropped.
  task automatic request(input int id, input logic [1:0] op, input logic [15:0] a,
                         input logic [3:0] imm, output bit ok);
    @(negedge clk);
    if (id == 0) begin
      bus.Req_Op0 = op; bus.Req_A0 = a; bus.Req_Imm0 = imm;
    end else begin
      bus.Req_Op1 = op; bus.Req_A1 = a; bus.Req_Imm1 = imm;
    end
    bus.Req_Valid[id] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      #1;
      if (bus.Req_Ready[id]) ok = 1'b1;
      else @(negedge clk);
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL accept_timeout id=%0d: Req_Ready=%b, required accept within 20 cycles", id, bus.Req_Ready);
    end
    @(negedge clk);
    #1;
    bus.Req_Valid[id] = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.Req_Valid = 2'b11;
    #3;
    vectors++; if (bus.Req_Ready !== 2'b00) begin miscompares++; $display("FAIL reset_req_ready: got %b want 00", bus.Req_Ready); end
    vectors++; if (bus.Rsp_Valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", bus.Rsp_Valid); end
    vectors++; if (bus.Rsp_Data !== 16'h0000) begin miscompares++; $display("FAIL reset_rsp_data: got %h want 0000", bus.Rsp_Data); end
    vectors++; if (bus.Rsp_Id !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_id: got %b want 0", bus.Rsp_Id); end
    vectors++; if ({sh_a, sh_imm, sh_ctrl} !== 22'd0) begin miscompares++; $display("FAIL reset_sh: got A=%h Imm=%h Ctrl=%b want 0", sh_a, sh_imm, sh_ctrl); end
    bus.Req_Valid = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sll();
    bit ok;
    request(0, SLL, 16'h00F1, 4'd4, ok);
    vectors++; if (bus.Rsp_Valid !== 1'b0) begin miscompares++; $display("FAIL sll_c1_valid: got %b want 0", bus.Rsp_Valid); end
    vectors++; if ({sh_a, sh_imm, sh_ctrl} !== {16'h00F1, 4'd4, 2'b00}) begin miscompares++; $display("FAIL sll_c1_sh: got A=%h Imm=%0d Ctrl=%b want 00f1/4/00", sh_a, sh_imm, sh_ctrl); end
    next_cycle();
    vectors++; if ({bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Id} !== {1'b1, 16'h0F10, 1'b0}) begin miscompares++; $display("FAIL sll_c2_rsp: got v=%b d=%h id=%b want 1/0f10/0", bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Id); end
    vectors++; if ({sh_a, sh_imm, sh_ctrl} !== 22'd0) begin miscompares++; $display("FAIL sll_c2_sh_idle: got A=%h Imm=%0d Ctrl=%b want 0", sh_a, sh_imm, sh_ctrl); end
    next_cycle();
    vectors++; if (bus.Rsp_Valid !== 1'b0) begin miscompares++; $display("FAIL sll_c3_valid: got %b want 0", bus.Rsp_Valid); end
  endtask

  task automatic test_sra_srl();
    bit ok;
    request(1, SRA, 16'h8000, 4'd15, ok);
    vectors++; if (sh_ctrl !== 2'b11) begin miscompares++; $display("FAIL sra_ctrl: got %b want 11", sh_ctrl); end
    next_cycle();
    vectors++; if ({bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Id} !== {1'b1, 16'hFFFF, 1'b1}) begin miscompares++; $display("FAIL sra_rsp: got v=%b d=%h id=%b want 1/ffff/1", bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Id); end
    request(0, SRL, 16'h8000, 4'd15, ok);
    vectors++; if (sh_ctrl !== 2'b10) begin miscompares++; $display("FAIL srl_ctrl: got %b want 10", sh_ctrl); end
    next_cycle();
    vectors++; if ({bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Id} !== {1'b1, 16'h0001, 1'b0}) begin miscompares++; $display("FAIL srl_rsp: got v=%b d=%h id=%b want 1/0001/0", bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Id); end
  endtask

  task automatic test_ror();
    bit ok;
    request(0, ROR, 16'h1234, 4'd4, ok);
    vectors++; if ({sh_a, sh_imm, sh_ctrl} !== {16'h1234, 4'd4, 2'b10}) begin miscompares++; $display("FAIL ror_pass1_sh: got A=%h Imm=%0d Ctrl=%b want 1234/4/10", sh_a, sh_imm, sh_ctrl); end
    next_cycle();
    vectors++; if ({sh_a, sh_imm, sh_ctrl} !== {16'h1234, 4'd12, 2'b00}) begin miscompares++; $display("FAIL ror_pass2_sh: got A=%h Imm=%0d Ctrl=%b want 1234/12/00", sh_a, sh_imm, sh_ctrl); end
    vectors++; if (bus.Rsp_Valid !== 1'b0) begin miscompares++; $display("FAIL ror_c2_valid: got %b want 0", bus.Rsp_Valid); end
    next_cycle();
    vectors++; if ({bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Id} !== {1'b1, 16'h4123, 1'b0}) begin miscompares++; $display("FAIL ror_rsp: got v=%b d=%h id=%b want 1/4123/0", bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Id); end
    request(1, ROR, 16'h1234, 4'd0, ok);
    next_cycle();
    vectors++; if ({bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Id} !== {1'b1, 16'h1234, 1'b1}) begin miscompares++; $display("FAIL ror0_rsp: got v=%b d=%h id=%b want 1/1234/1", bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Id); end
  endtask

  task automatic test_contention();
    int n;
    logic [15:0] exp_data [4];
    logic        got_id   [4];
    logic [15:0] got_data [4];
    int          got_cyc  [4];
    bit          both_ready;
    exp_data = '{16'h0006, 16'h0010, 16'h0006, 16'h0010};
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.Req_Op0 = SLL; bus.Req_A0 = 16'h0003; bus.Req_Imm0 = 4'd1;
    bus.Req_Op1 = SRL; bus.Req_A1 = 16'h0100; bus.Req_Imm1 = 4'd4;
    bus.Req_Valid = 2'b11;
    n = 0;
    both_ready = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      if (bus.Req_Ready == 2'b11) both_ready = 1'b1;
      if (bus.Rsp_Valid === 1'b1 && n < 4) begin
        got_id[n] = bus.Rsp_Id; got_data[n] = bus.Rsp_Data; got_cyc[n] = c; n++;
      end
    end
    bus.Req_Valid = 2'b00;
    vectors++; if (n !== 4) begin miscompares++; $display("FAIL contention_count: got %0d responses want 4", n); end
    vectors++; if (both_ready) begin miscompares++; $display("FAIL contention_ready: got Req_Ready=11 want at most one bit"); end
    for (int k = 0; k < n; k++) begin
      vectors++;
      if (got_id[k] !== k[0] || got_data[k] !== exp_data[k] || got_cyc[k] != 2 + 3 * k) begin
        miscompares++;
        $display("FAIL contention_rsp%0d: got id=%b d=%h cyc=%0d want id=%b d=%h cyc=%0d",
                 k, got_id[k], got_data[k], got_cyc[k], k[0], exp_data[k], 2 + 3 * k);
      end
    end
    repeat (4) next_cycle();
  endtask

  task automatic test_backpressure();
    bit ok;
    bit unstable;
    bus.Rsp_Ready = 1'b0;
    request(0, SRL, 16'hF000, 4'd8, ok);
    bus.Req_Op1 = SLL; bus.Req_A1 = 16'h0001; bus.Req_Imm1 = 4'd15;
    bus.Req_Valid[1] = 1'b1;
    unstable = 1'b0;
    for (int c = 2; c <= 6; c++) begin
      next_cycle();
      if ({bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Id, bus.Req_Ready} !== {1'b1, 16'h00F0, 1'b0, 2'b00}) begin
        unstable = 1'b1;
        $display("cycle %0d: v=%b d=%h id=%b ready=%b", c, bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Id, bus.Req_Ready);
      end
    end
    vectors++; if (unstable) begin miscompares++; $display("FAIL backpressure_hold: response or Req_Ready changed, want 1/00f0/0 ready=00"); end
    bus.Rsp_Ready = 1'b1;
    next_cycle();
    vectors++; if ({bus.Rsp_Valid, bus.Req_Ready} !== {1'b0, 2'b10}) begin miscompares++; $display("FAIL backpressure_release: got v=%b ready=%b want 0/10", bus.Rsp_Valid, bus.Req_Ready); end
    next_cycle();
    bus.Req_Valid[1] = 1'b0;
    vectors++; if ({sh_a, sh_imm, sh_ctrl} !== {16'h0001, 4'd15, 2'b00}) begin miscompares++; $display("FAIL backpressure_next_accept: got A=%h Imm=%0d Ctrl=%b want 0001/15/00", sh_a, sh_imm, sh_ctrl); end
    next_cycle();
    vectors++; if ({bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Id} !== {1'b1, 16'h8000, 1'b1}) begin miscompares++; $display("FAIL backpressure_next_rsp: got v=%b d=%h id=%b want 1/8000/1", bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Id); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit pulse;
    request(1, ROR, 16'h1234, 4'd4, ok);
    next_cycle();
    vectors++; if ({sh_imm, sh_ctrl} !== {4'd12, 2'b00}) begin miscompares++; $display("FAIL midreset_in_pass2: got Imm=%0d Ctrl=%b want 12/00", sh_imm, sh_ctrl); end
    rst_n = 1'b0;
    #1;
    vectors++; if ({sh_a, sh_imm, sh_ctrl, bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Id, bus.Req_Ready} !== 42'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got A=%h Imm=%0d Ctrl=%b v=%b d=%h id=%b ready=%b want all 0",
               sh_a, sh_imm, sh_ctrl, bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Id, bus.Req_Ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulse = 1'b0;
    repeat (4) begin
      next_cycle();
      if (bus.Rsp_Valid !== 1'b0) pulse = 1'b1;
    end
    vectors++; if (pulse) begin miscompares++; $display("FAIL midreset_no_rsp: got Rsp_Valid=1 after reset want 0"); end
    request(1, SRA, 16'h4000, 4'd2, ok);
    next_cycle();
    vectors++; if ({bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Id} !== {1'b1, 16'h1000, 1'b1}) begin miscompares++; $display("FAIL midreset_recover: got v=%b d=%h id=%b want 1/1000/1", bus.Rsp_Valid, bus.Rsp_Data, bus.Rsp_Id); end
    next_cycle();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.Req_Valid = 2'b00;
    bus.Req_Op0 = SLL; bus.Req_Op1 = SLL;
    bus.Req_A0 = 16'h0; bus.Req_A1 = 16'h0;
    bus.Req_Imm0 = 4'd0; bus.Req_Imm1 = 4'd0;
    bus.Rsp_Ready = 1'b1;
    test_reset();
    test_sll();
    test_sra_srl();
    test_ror();
    test_contention();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
